// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

    // Scan FSM: all anodes off (anti-ghost gap) or one digit driven.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Segment pattern with every segment off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex glyphs, active-low {g,f,e,d,c,b,a}; entry N is the glyph for nibble N.
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Largest of two tick counts, never below 2, so the counter is at least 1 bit.
    function automatic int max_ticks(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 2) ? m : 2;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph lookup.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Values are staged in a shadow set and copied to the active set only at the
// frame boundary (index wrap), so a frame never mixes old and new digits.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_BLANK | all anodes off for BLANK_TICKS cycles before digit idx
//   ST_SHOW  | digit idx driven for DIGIT_TICKS cycles, then idx advances
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzb_in,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_pulse,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int VAL_W  = 4 * NUM_DIGITS;
    localparam int TICK_W = $clog2(max_ticks(DIGIT_TICKS, BLANK_TICKS));
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TICK_W-1:0]     DIGIT_LAST = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [TICK_W-1:0]     BLANK_LAST = TICK_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT_ONE  = NUM_DIGITS'(1);

    state_t              state, state_nxt;
    logic [TICK_W-1:0]   tick, tick_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic                boundary;

    logic [VAL_W-1:0]      shadow_value, active_value;
    logic [NUM_DIGITS-1:0] shadow_en, active_en;
    logic [NUM_DIGITS-1:0] shadow_dp, active_dp;
    logic                  shadow_lzb, active_lzb;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  lz_run;
    logic [3:0]            cur_nibble;
    logic                  digit_lit;
    logic [6:0]            hex_seg;

    // State register; reset lands in BLANK so the first digit also gets its gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, tick and index sequencing; boundary marks the last-digit wrap.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tick_nxt  = tick + 1'b1;
        boundary  = 1'b0;
        case (state)
            ST_BLANK: begin
                if (BLANK_TICKS == 0 || tick == BLANK_LAST) begin
                    state_nxt = ST_SHOW;
                    tick_nxt  = '0;
                end
            end
            ST_SHOW: begin
                if (tick == DIGIT_LAST) begin
                    tick_nxt  = '0;
                    state_nxt = (BLANK_TICKS == 0) ? ST_SHOW : ST_BLANK;
                    if (idx == IDX_LAST) begin
                        idx_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_BLANK;
                tick_nxt  = '0;
            end
        endcase
    end

    // Tick counter and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= '0;
            idx  <= '0;
        end else begin
            tick <= tick_nxt;
            idx  <= idx_nxt;
        end
    end

    // Shadow capture on load; last load before the boundary wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_en    <= '0;
            shadow_dp    <= '0;
            shadow_lzb   <= 1'b0;
        end else if (load) begin
            shadow_value <= value_in;
            shadow_en    <= en_in;
            shadow_dp    <= dp_in;
            shadow_lzb   <= lzb_in;
        end
    end

    // Boundary transfer uses the shadow as it stood before this cycle's load,
    // so a load coinciding with the wrap waits for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_value <= '0;
            active_en    <= '0;
            active_dp    <= '0;
            active_lzb   <= 1'b0;
            pending      <= 1'b0;
            frame_pulse  <= 1'b0;
        end else begin
            frame_pulse <= boundary && pending;
            if (boundary && pending) begin
                active_value <= shadow_value;
                active_en    <= shadow_en;
                active_dp    <= shadow_dp;
                active_lzb   <= shadow_lzb;
            end
            if (load) begin
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    // Leading-zero mask: blank from the top digit down while nibbles are zero;
    // digit 0 is never masked so a zero value still reads "0".
    always_comb begin
        lz_run  = active_lzb;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run     = lz_run && (active_value[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_run;
        end
    end

    // Select the current nibble and decide whether this slot lights.
    always_comb begin
        cur_nibble = active_value[{idx, 2'b00} +: 4];
        digit_lit  = (state == ST_SHOW) && active_en[idx] && !lz_mask[idx];
    end

    seg_hex_decode u_hex (
        .nibble (cur_nibble),
        .seg    (hex_seg)
    );

    // Registered pin drivers: seg, dp and an change together, one cycle behind the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (digit_lit) begin
            an  <= ~(DIGIT_ONE << idx);
            seg <= hex_seg;
            dp  <= ~active_dp[idx];
        end else begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 4-cycle digit, 2-cycle gap).
// A queue holds staged configurations; the frame model pops one per applied boundary
// and predicts every output cycle, while each test task checks its own scenario.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DT    = 4;
    localparam int BT    = 2;
    localparam int FRAME = ND * (DT + BT);

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  en;
        logic [3:0]  dpm;
        logic        lzb;
    } cfg_t;

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic [3:0]  en_in;
    logic [3:0]  dp_in;
    logic        lzb_in;
    logic        load;
    logic        pending;
    logic        frame_pulse;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    cfg_t sbq[$];
    cfg_t m_active = '0;
    logic [3:0] exp_an    = 4'hF;
    logic [6:0] exp_seg   = 7'h7F;
    logic       exp_dp    = 1'b1;
    logic       exp_pulse = 1'b0;
    logic       exp_pend  = 1'b0;

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .en_in       (en_in),
        .dp_in       (dp_in),
        .lzb_in      (lzb_in),
        .load        (load),
        .pending     (pending),
        .frame_pulse (frame_pulse),
        .seg         (seg),
        .dp          (dp),
        .an          (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // {an, seg, dp} for slot s of configuration c while that slot is shown.
    function automatic logic [11:0] slot_out(input cfg_t c, input int s);
        logic       blank;
        logic [3:0] a;
        logic [3:0] nib;
        blank = c.lzb && (s != 0);
        for (int j = s; j < ND; j++) begin
            if (c.value[4*j +: 4] != 4'h0) blank = 1'b0;
        end
        if (!c.en[s] || blank) return {4'hF, 7'h7F, 1'b1};
        a    = 4'hF;
        a[s] = 1'b0;
        nib  = c.value[4*s +: 4];
        return {a, seg_of(nib), ~c.dpm[s]};
    endfunction

    // Frame model: outputs in cycle n reflect the scan position of cycle n-1.
    initial begin
        forever begin
            int   p;
            cfg_t c;
            @(posedge clk);
            if (rst) begin
                cyc       = 0;
                m_active  = '0;
                sbq.delete();
                exp_an    = 4'hF;
                exp_seg   = 7'h7F;
                exp_dp    = 1'b1;
                exp_pulse = 1'b0;
                exp_pend  = 1'b0;
            end else begin
                p = cyc % FRAME;
                if ((p % (DT + BT)) >= BT)
                    {exp_an, exp_seg, exp_dp} = slot_out(m_active, p / (DT + BT));
                else
                    {exp_an, exp_seg, exp_dp} = {4'hF, 7'h7F, 1'b1};
                cyc       = cyc + 1;
                exp_pulse = 1'b0;
                if ((cyc % FRAME) == 0 && sbq.size() > 0) begin
                    m_active  = sbq.pop_front();
                    exp_pulse = 1'b1;
                end
                if (load) begin
                    c = '{value: value_in, en: en_in, dpm: dp_in, lzb: lzb_in};
                    if (sbq.size() > 0) sbq[sbq.size()-1] = c;
                    else sbq.push_back(c);
                end
                exp_pend = (sbq.size() > 0);
            end
        end
    end

    // Scoreboard compare of every output, every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            n_checks++;
            if (rst) begin
                if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || pending !== 1'b0 || frame_pulse !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sb_reset t=%0t got an=%b seg=%b dp=%b pend=%b pulse=%b expected dark and idle", $time, an, seg, dp, pending, frame_pulse);
                end
            end else if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || pending !== exp_pend || frame_pulse !== exp_pulse) begin
                n_fail++;
                $display("FAIL sb_cycle cyc=%0d got an=%b seg=%b dp=%b pend=%b pulse=%b expected an=%b seg=%b dp=%b pend=%b pulse=%b",
                         cyc, an, seg, dp, pending, frame_pulse, exp_an, exp_seg, exp_dp, exp_pend, exp_pulse);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_phase(input int p);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 3 * FRAME && !hit; k++) begin
            @(negedge clk);
            hit = ((cyc % FRAME) == p);
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_phase phase %0d not reached, now at %0d", p, cyc % FRAME);
        end
    endtask

    task automatic drive_load(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d, input logic z);
        value_in = v;
        en_in    = e;
        dp_in    = d;
        lzb_in   = z;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; load = 1'b0; value_in = '0; en_in = '0; dp_in = '0; lzb_in = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || pending !== 1'b0 || frame_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init got an=%b seg=%b dp=%b pend=%b expected an=1111 seg=1111111 dp=1 pend=0", an, seg, dp, pending);
        end
        rst = 1'b0;
        wait_phase(2);
        drive_load(16'h9876, 4'hF, 4'h0, 1'b0);
        wait_phase(2);
        drive_load(16'h4321, 4'hF, 4'h0, 1'b0);
        n_checks++;
        if (an !== 4'b1110 || seg !== 7'b0000010 || pending !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre got an=%b seg=%b pend=%b expected an=1110 seg=0000010 pend=1", an, seg, pending);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async got an=%b seg=%b dp=%b pend=%b expected an=1111 seg=1111111 dp=1 pend=0", an, seg, dp, pending);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_checks++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || pending !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_dark k=%0d got an=%b seg=%b dp=%b pend=%b expected dark, pend=0", k, an, seg, dp, pending);
            end
        end
    endtask

    task automatic test_scan;
        logic [3:0] an_e  [4];
        logic [6:0] seg_e [4];
        logic       dp_e  [4];
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        int         s;
        an_e  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_e = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
        dp_e  = '{1'b1, 1'b0, 1'b1, 1'b1};
        wait_phase(2);
        drive_load(16'h12AF, 4'hF, 4'b0010, 1'b0);
        wait_phase(0);
        n_checks++;
        if (frame_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_pulse got %b expected 1", frame_pulse);
        end
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            s = (k - 1) / (DT + BT);
            if (((k - 1) % (DT + BT)) >= BT) begin
                ea = an_e[s]; es = seg_e[s]; ed = dp_e[s];
            end else begin
                ea = 4'hF; es = 7'h7F; ed = 1'b1;
            end
            n_checks++;
            if (an !== ea || seg !== es || dp !== ed) begin
                n_fail++;
                $display("FAIL scan k=%0d got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b", k, an, seg, dp, ea, es, ed);
            end
        end
    endtask

    task automatic test_lzb;
        logic [3:0] an_e  [4];
        logic [6:0] seg_e [4];
        logic [3:0] ea;
        logic [6:0] es;
        int         s;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                an_e  = '{4'b1110, 4'b1101, 4'hF, 4'hF};
                seg_e = '{7'b1000000, 7'b0010010, 7'h7F, 7'h7F};
            end else begin
                an_e  = '{4'b1110, 4'hF, 4'hF, 4'hF};
                seg_e = '{7'b1000000, 7'h7F, 7'h7F, 7'h7F};
            end
            wait_phase(2);
            drive_load((c == 0) ? 16'h0050 : 16'h0000, 4'hF, 4'h0, 1'b1);
            wait_phase(0);
            for (int k = 1; k <= FRAME; k++) begin
                @(negedge clk);
                s = (k - 1) / (DT + BT);
                if (((k - 1) % (DT + BT)) >= BT) begin
                    ea = an_e[s]; es = seg_e[s];
                end else begin
                    ea = 4'hF; es = 7'h7F;
                end
                n_checks++;
                if (an !== ea || seg !== es || dp !== 1'b1) begin
                    n_fail++;
                    $display("FAIL lzb case=%0d k=%0d got an=%b seg=%b dp=%b expected an=%b seg=%b dp=1", c, k, an, seg, dp, ea, es);
                end
            end
        end
    endtask

    task automatic test_mid_frame_load;
        bit hit;
        wait_phase(9);
        drive_load(16'h3333, 4'hF, 4'h0, 1'b0);
        n_checks++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL midload_pending got %b expected 1", pending);
        end
        hit = 1'b0;
        for (int k = 0; k < FRAME && !hit; k++) begin
            n_checks++;
            if (an !== 4'hF) begin
                n_fail++;
                $display("FAIL midload_old got an=%b expected 1111", an);
            end
            @(negedge clk);
            hit = ((cyc % FRAME) == 0);
        end
        n_checks++;
        if (frame_pulse !== 1'b1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_wrap got pulse=%b pend=%b expected pulse=1 pend=0", frame_pulse, pending);
        end
        wait_phase(3);
        n_checks++;
        if (an !== 4'b1110 || seg !== 7'b0110000) begin
            n_fail++;
            $display("FAIL midload_new got an=%b seg=%b expected an=1110 seg=0110000", an, seg);
        end
    endtask

    task automatic test_back_to_back;
        wait_phase(4);
        drive_load(16'h1111, 4'hF, 4'h0, 1'b0);
        wait_phase(10);
        drive_load(16'h2222, 4'hF, 4'h0, 1'b0);
        wait_phase(0);
        n_checks++;
        if (frame_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pulse got %b expected 1", frame_pulse);
        end
        wait_phase(3);
        n_checks++;
        if (seg !== 7'b0100100) begin
            n_fail++;
            $display("FAIL b2b_last_wins got seg=%b expected 0100100", seg);
        end
        // load on the wrap cycle with nothing pending
        wait_phase(FRAME - 1);
        drive_load(16'h4444, 4'hF, 4'h0, 1'b0);
        n_checks++;
        if (frame_pulse !== 1'b0 || pending !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_idle got pulse=%b pend=%b expected pulse=0 pend=1", frame_pulse, pending);
        end
        wait_phase(3);
        n_checks++;
        if (seg !== 7'b0100100) begin
            n_fail++;
            $display("FAIL edge_idle_hold got seg=%b expected 0100100", seg);
        end
        wait_phase(0);
        n_checks++;
        if (frame_pulse !== 1'b1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_idle_next got pulse=%b pend=%b expected pulse=1 pend=0", frame_pulse, pending);
        end
        wait_phase(3);
        n_checks++;
        if (seg !== 7'b0011001) begin
            n_fail++;
            $display("FAIL edge_idle_apply got seg=%b expected 0011001", seg);
        end
        // load on the wrap cycle while an older load is pending
        wait_phase(10);
        drive_load(16'h5555, 4'hF, 4'h0, 1'b0);
        wait_phase(FRAME - 1);
        drive_load(16'h6666, 4'hF, 4'h0, 1'b0);
        n_checks++;
        if (frame_pulse !== 1'b1 || pending !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_busy got pulse=%b pend=%b expected pulse=1 pend=1", frame_pulse, pending);
        end
        wait_phase(3);
        n_checks++;
        if (seg !== 7'b0010010) begin
            n_fail++;
            $display("FAIL edge_busy_prior got seg=%b expected 0010010", seg);
        end
        wait_phase(0);
        n_checks++;
        if (frame_pulse !== 1'b1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_busy_next got pulse=%b pend=%b expected pulse=1 pend=0", frame_pulse, pending);
        end
        wait_phase(3);
        n_checks++;
        if (seg !== 7'b0000010) begin
            n_fail++;
            $display("FAIL edge_busy_apply got seg=%b expected 0000010", seg);
        end
    endtask

    task automatic test_masks;
        logic [3:0] an_e  [4];
        logic [6:0] seg_e [4];
        logic [3:0] ea;
        logic [6:0] es;
        int         s;
        int         dark;
        an_e  = '{4'b1110, 4'hF, 4'b1011, 4'hF};
        seg_e = '{7'b0011001, 7'h7F, 7'b0100100, 7'h7F};
        dark  = 0;
        wait_phase(2);
        drive_load(16'h1234, 4'b0101, 4'h0, 1'b0);
        wait_phase(0);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            s = (k - 1) / (DT + BT);
            if (((k - 1) % (DT + BT)) >= BT) begin
                ea = an_e[s]; es = seg_e[s];
            end else begin
                ea = 4'hF; es = 7'h7F;
            end
            if (an === 4'hF) dark++;
            n_checks++;
            if (an === 4'b1101 || an === 4'b0111 || an !== ea || seg !== es) begin
                n_fail++;
                $display("FAIL mask k=%0d got an=%b seg=%b expected an=%b seg=%b", k, an, seg, ea, es);
            end
        end
        n_checks++;
        if (dark !== 2 * DT + ND * BT) begin
            n_fail++;
            $display("FAIL mask_dark_cycles got %0d expected %0d", dark, 2 * DT + ND * BT);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lzb();
        test_mid_frame_load();
        test_back_to_back();
        test_masks();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
